// File: rtl/rename_pkg.sv
// Shared types for the rename stage: physical register ids, RAT entries and retire ports.
package rename_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int CREG_NUM    = 32;
  localparam int PREG_NUM    = 64;
  localparam int PW          = $clog2(PREG_NUM);
  localparam int CW          = $clog2(CREG_NUM);
  localparam int NW          = $clog2(FETCH_WIDTH + 1);

  typedef logic [PW-1:0] preg_addr_t;
  typedef logic [CW-1:0] creg_addr_t;
  typedef logic [PW:0]   preg_cnt_t;
  typedef logic [NW-1:0] slot_cnt_t;

  typedef struct packed {
    logic       valid;
    preg_addr_t id;
  } rat_entry_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t dst;
    preg_addr_t pdst;
  } retire_t;

  function automatic slot_cnt_t popcount_fw(input logic [FETCH_WIDTH-1:0] v);
    slot_cnt_t c;
    c = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      c = c + slot_cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rename_table_checker.sv
// Simulation-only protocol checks on free-list occupancy (no overflow from retires, no underflow).
module free_list_checker
  import rename_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  preg_cnt_t              count_i,
  input  slot_cnt_t              pop_cnt_i,
  input  logic [FETCH_WIDTH-1:0] push_valid_i
);

  int occ_next_s;

  // Occupancy the list would hold after this cycle's pops and pushes.
  always_comb begin
    occ_next_s = int'(count_i) - int'(pop_cnt_i);
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      if (push_valid_i[j]) begin
        occ_next_s = occ_next_s + 1;
      end else begin
        occ_next_s = occ_next_s;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (flush_i || (occ_next_s <= PREG_NUM)));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (flush_i || (occ_next_s >= 0)));

endmodule

// File: rtl/rename_table_free_list.sv
// Circular FIFO of free physical registers: FW reads at head offsets, FW ordered pushes at tail.
module free_list
  import rename_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  slot_cnt_t                    pop_cnt_i,
  input  preg_addr_t [FETCH_WIDTH-1:0] rd_off_i,
  output preg_addr_t [FETCH_WIDTH-1:0] rd_id_o,
  input  logic [FETCH_WIDTH-1:0]       push_valid_i,
  input  preg_addr_t [FETCH_WIDTH-1:0] push_id_i,
  output preg_cnt_t                    count_o
);

  preg_addr_t fl_q [PREG_NUM];
  preg_addr_t fl_d [PREG_NUM];
  preg_addr_t head_q, head_d;
  preg_addr_t tail_q, tail_d;
  preg_cnt_t  count_q, count_d;
  preg_addr_t push_cnt_s;

  // Head-relative read ports; pointer sums wrap naturally at PREG_NUM.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rd_id_o[i] = fl_q[head_q + rd_off_i[i]];
    end
  end

  // Next-state: flush rebuilds the identity list, otherwise pop at head and push in port order.
  always_comb begin
    fl_d       = fl_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push_cnt_s = '0;
    if (flush_i) begin
      for (int k = 0; k < PREG_NUM; k++) begin
        fl_d[k] = preg_addr_t'(k);
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = preg_cnt_t'(PREG_NUM);
    end else begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (push_valid_i[j]) begin
          fl_d[tail_q + push_cnt_s] = push_id_i[j];
          push_cnt_s = push_cnt_s + preg_addr_t'(1'b1);
        end else begin
          push_cnt_s = push_cnt_s;
        end
      end
      head_d  = head_q + preg_addr_t'(pop_cnt_i);
      tail_d  = tail_q + push_cnt_s;
      count_d = count_q - preg_cnt_t'(pop_cnt_i) + preg_cnt_t'(push_cnt_s);
    end
  end

  // State registers with asynchronous return to the identity list.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < PREG_NUM; k++) begin
        fl_q[k] <= preg_addr_t'(k);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= preg_cnt_t'(PREG_NUM);
    end else begin
      fl_q    <= fl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

  free_list_checker u_chk (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .flush_i      (flush_i),
    .count_i      (count_q),
    .pop_cnt_i    (pop_cnt_i),
    .push_valid_i (push_valid_i)
  );

endmodule

// File: rtl/rename_table.sv
// Register alias table plus free list: answers source lookups, allocates destinations,
// commits mappings on rename_fire and reclaims registers from retirement.
module rename_table
  import rename_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [FETCH_WIDTH-1:0]       req_valid_i,
  input  creg_addr_t [FETCH_WIDTH-1:0] req_src1_i,
  input  creg_addr_t [FETCH_WIDTH-1:0] req_src2_i,
  input  creg_addr_t [FETCH_WIDTH-1:0] req_dst_i,
  input  logic [FETCH_WIDTH-1:0]       req_wen_i,
  input  logic                         rename_fire_i,
  output rat_entry_t [FETCH_WIDTH-1:0] psrc1_o,
  output rat_entry_t [FETCH_WIDTH-1:0] psrc2_o,
  output rat_entry_t [FETCH_WIDTH-1:0] pdst_o,
  output logic                         stall_o,
  input  logic [FETCH_WIDTH-1:0]       retire_valid_i,
  input  creg_addr_t [FETCH_WIDTH-1:0] retire_dst_i,
  input  preg_addr_t [FETCH_WIDTH-1:0] retire_pdst_i,
  output preg_cnt_t                    free_count_o
);

  rat_entry_t rat_q [CREG_NUM];
  rat_entry_t rat_d [CREG_NUM];

  logic [FETCH_WIDTH-1:0]       need_s;
  slot_cnt_t                    need_cnt_s;
  slot_cnt_t                    pop_cnt_s;
  logic                         stall_s;
  logic                         commit_s;
  preg_addr_t [FETCH_WIDTH-1:0] rd_off_s;
  preg_addr_t [FETCH_WIDTH-1:0] rd_id_s;
  rat_entry_t [FETCH_WIDTH-1:0] pdst_s;
  retire_t [FETCH_WIDTH-1:0]    retire_s;
  logic [FETCH_WIDTH-1:0]       push_valid_s;
  preg_addr_t [FETCH_WIDTH-1:0] push_id_s;
  preg_cnt_t                    free_count_s;

  // Allocation demand per slot; x0 never receives a mapping.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      need_s[i] = req_valid_i[i] & req_wen_i[i] & (req_dst_i[i] != '0);
    end
  end

  assign need_cnt_s = popcount_fw(need_s);
  assign stall_s    = preg_cnt_t'(need_cnt_s) > free_count_s;
  assign commit_s   = rename_fire_i & ~stall_s & ~flush_i;
  assign pop_cnt_s  = commit_s ? need_cnt_s : '0;

  // Each slot takes the free entry after those claimed by lower allocating slots.
  always_comb begin
    preg_addr_t acc_s;
    acc_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rd_off_s[i] = acc_s;
      acc_s       = acc_s + preg_addr_t'(need_s[i]);
    end
  end

  // Allocated destinations, valid only for slots that need one.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      pdst_s[i].valid = need_s[i];
      pdst_s[i].id    = rd_id_s[i];
    end
  end

  // Source lookups straight from the registered RAT.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (req_src1_i[i] == '0) begin
        psrc1_o[i] = '0;
      end else begin
        psrc1_o[i] = rat_q[req_src1_i[i]];
      end
      if (req_src2_i[i] == '0) begin
        psrc2_o[i] = '0;
      end else begin
        psrc2_o[i] = rat_q[req_src2_i[i]];
      end
    end
  end

  // Bundle the retire ports and feed them to the free-list tail.
  always_comb begin
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      retire_s[j]     = '{valid: retire_valid_i[j], dst: retire_dst_i[j], pdst: retire_pdst_i[j]};
      push_valid_s[j] = retire_s[j].valid;
      push_id_s[j]    = retire_s[j].pdst;
    end
  end

  // RAT next state: retire clears first, rename writes override them, higher slot last.
  always_comb begin
    rat_d = rat_q;
    if (flush_i) begin
      for (int k = 0; k < CREG_NUM; k++) begin
        rat_d[k] = '0;
      end
    end else begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (retire_s[j].valid && rat_q[retire_s[j].dst].valid &&
            (rat_q[retire_s[j].dst].id == retire_s[j].pdst)) begin
          rat_d[retire_s[j].dst].valid = 1'b0;
        end else begin
          rat_d[retire_s[j].dst].valid = rat_d[retire_s[j].dst].valid;
        end
      end
      if (commit_s) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (need_s[i]) begin
            rat_d[req_dst_i[i]] = pdst_s[i];
          end else begin
            rat_d[req_dst_i[i]] = rat_d[req_dst_i[i]];
          end
        end
      end else begin
        rat_d[0] = rat_d[0];
      end
    end
  end

  // RAT registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < CREG_NUM; k++) begin
        rat_q[k] <= '0;
      end
    end else begin
      rat_q <= rat_d;
    end
  end

  free_list u_free_list (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .flush_i      (flush_i),
    .pop_cnt_i    (pop_cnt_s),
    .rd_off_i     (rd_off_s),
    .rd_id_o      (rd_id_s),
    .push_valid_i (push_valid_s),
    .push_id_i    (push_id_s),
    .count_o      (free_count_s)
  );

  assign pdst_o       = pdst_s;
  assign stall_o      = stall_s;
  assign free_count_o = free_count_s;

endmodule

// File: tb/tb_rename_table.sv
// Directed bench for rename_table with a queue-based reference model checked every cycle.
module tb_rename_table;
  import rename_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush;
  logic [FETCH_WIDTH-1:0]       req_valid, req_wen, retire_valid;
  creg_addr_t [FETCH_WIDTH-1:0] req_src1, req_src2, req_dst, retire_dst;
  preg_addr_t [FETCH_WIDTH-1:0] retire_pdst;
  logic                         rename_fire;
  rat_entry_t [FETCH_WIDTH-1:0] psrc1, psrc2, pdst;
  logic                         stall;
  preg_cnt_t                    free_count;

  int checks = 0;
  int errors = 0;

  rename_table dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_src1_i     (req_src1),
    .req_src2_i     (req_src2),
    .req_dst_i      (req_dst),
    .req_wen_i      (req_wen),
    .rename_fire_i  (rename_fire),
    .psrc1_o        (psrc1),
    .psrc2_o        (psrc2),
    .pdst_o         (pdst),
    .stall_o        (stall),
    .retire_valid_i (retire_valid),
    .retire_dst_i   (retire_dst),
    .retire_pdst_i  (retire_pdst),
    .free_count_o   (free_count)
  );

  always #5 clk = ~clk;

  // Reference model: architectural map as arrays, free list as a FIFO queue.
  typedef struct { int dst; int pdst; } pair_t;
  int    m_fl[$];
  bit    m_v  [CREG_NUM];
  int    m_id [CREG_NUM];
  pair_t inflight[$];

  function automatic void chk(string nm, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endfunction

  function automatic void m_init();
    m_fl.delete();
    for (int k = 0; k < PREG_NUM; k++) m_fl.push_back(k);
    for (int c = 0; c < CREG_NUM; c++) begin
      m_v[c]  = 1'b0;
      m_id[c] = 0;
    end
    inflight.delete();
  endfunction

  function automatic void m_step();
    bit need [FETCH_WIDTH];
    bit nv   [CREG_NUM];
    int nid  [CREG_NUM];
    int n, k, d;
    bit commit;
    n = 0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      need[i] = req_valid[i] && req_wen[i] && (req_dst[i] != 0);
      n += int'(need[i]);
    end
    commit = rename_fire && (n <= m_fl.size());
    nv  = m_v;
    nid = m_id;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      d = int'(retire_dst[j]);
      if (retire_valid[j] && m_v[d] && (m_id[d] == int'(retire_pdst[j]))) nv[d] = 1'b0;
    end
    k = 0;
    if (commit) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (need[i]) begin
          d = int'(req_dst[i]);
          nv[d]  = 1'b1;
          nid[d] = m_fl[k];
          inflight.push_back('{d, m_fl[k]});
          k++;
        end
      end
    end
    for (int p = 0; p < k; p++) void'(m_fl.pop_front());
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      if (retire_valid[j]) m_fl.push_back(int'(retire_pdst[j]));
    end
    m_v  = nv;
    m_id = nid;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || flush) m_init();
    else m_step();
  end

  function automatic void chk_src(string nm, rat_entry_t got, int src);
    bit ev;
    ev = (src != 0) && m_v[src];
    chk({nm, "_valid"}, int'(got.valid), int'(ev));
    if (ev) chk({nm, "_id"}, int'(got.id), m_id[src]);
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin : cmp
    int off;
    int ev;
    if (!reset) begin
      off = 0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        chk_src("psrc1", psrc1[i], int'(req_src1[i]));
        chk_src("psrc2", psrc2[i], int'(req_src2[i]));
        ev = (req_valid[i] && req_wen[i] && (req_dst[i] != 0)) ? 1 : 0;
        chk("pdst_valid", int'(pdst[i].valid), ev);
        if (off < m_fl.size()) chk("pdst_id", int'(pdst[i].id), m_fl[off]);
        off += ev;
      end
      chk("stall", int'(stall), (off > m_fl.size()) ? 1 : 0);
      chk("free_count", int'(free_count), m_fl.size());
    end
  end

  task automatic clear_in();
    flush = 1'b0; rename_fire = 1'b0;
    req_valid = '0; req_wen = '0; retire_valid = '0;
    req_src1 = '0; req_src2 = '0; req_dst = '0;
    retire_dst = '0; retire_pdst = '0;
  endtask

  task automatic set_slot(int i, bit v, bit w, int dst, int s1, int s2);
    req_valid[i] = v;
    req_wen[i]   = w;
    req_dst[i]   = creg_addr_t'(dst);
    req_src1[i]  = creg_addr_t'(s1);
    req_src2[i]  = creg_addr_t'(s2);
  endtask

  task automatic set_ret(int j, int dst, int pd);
    retire_valid[j] = 1'b1;
    retire_dst[j]   = creg_addr_t'(dst);
    retire_pdst[j]  = preg_addr_t'(pd);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pair_t p;
    int    nret;
    clear_in();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and first allocation of dst 5 and 6.
    set_slot(0, 1'b1, 1'b1, 5, 5, 0);
    set_slot(1, 1'b1, 1'b1, 6, 5, 6);
    rename_fire = 1'b1;
    #2;
    chk("rst_free_count", int'(free_count), 64);
    chk("rst_stall", int'(stall), 0);
    chk("rst_psrc_valid", int'(psrc1[0].valid), 0);
    chk("alloc_pdst0", int'(pdst[0]), 64 + 0);
    chk("alloc_pdst1", int'(pdst[1]), 64 + 1);
    tick();
    clear_in();
    set_slot(0, 1'b0, 1'b0, 0, 5, 6);
    #2;
    chk("lookup_src5", int'(psrc1[0]), 64 + 0);
    chk("lookup_src6", int'(psrc2[0]), 64 + 1);
    chk("count_62", int'(free_count), 62);

    // Both slots write dst 7: higher slot wins.
    set_slot(0, 1'b1, 1'b1, 7, 0, 0);
    set_slot(1, 1'b1, 1'b1, 7, 0, 0);
    rename_fire = 1'b1;
    #2;
    chk("dup_pdst0", int'(pdst[0]), 64 + 2);
    chk("dup_pdst1", int'(pdst[1]), 64 + 3);
    tick();
    clear_in();
    set_slot(0, 1'b0, 1'b0, 0, 7, 0);
    set_ret(0, 7, 2);
    #2;
    chk("dup_winner", int'(psrc1[0]), 64 + 3);
    chk("count_60", int'(free_count), 60);
    tick();
    clear_in();
    set_slot(0, 1'b0, 1'b0, 0, 7, 0);
    #2;
    chk("stale_retire_keeps", int'(psrc1[0]), 64 + 3);
    chk("count_61", int'(free_count), 61);

    // Retire and rename of the same dst in one cycle: rename wins.
    set_slot(0, 1'b1, 1'b1, 5, 0, 0);
    set_ret(0, 5, 0);
    rename_fire = 1'b1;
    #2;
    chk("prio_pdst", int'(pdst[0]), 64 + 4);
    tick();
    clear_in();
    set_slot(0, 1'b0, 1'b0, 0, 5, 0);
    set_ret(0, 6, 1);
    #2;
    chk("prio_rename_wins", int'(psrc1[0]), 64 + 4);
    tick();
    clear_in();
    set_slot(0, 1'b0, 1'b0, 0, 6, 0);
    #2;
    chk("retire_clears", int'(psrc1[0].valid), 0);
    chk("count_after_clear", int'(free_count), 62);

    // Drain to one free register, then stall on a two-slot bundle.
    for (int k = 0; k < 30; k++) begin
      clear_in();
      set_slot(0, 1'b1, 1'b1, 8 + (k % 20), k % 32, 5);
      set_slot(1, 1'b1, 1'b1, 9 + (k % 20), 7, (k * 3) % 32);
      rename_fire = 1'b1;
      tick();
    end
    clear_in();
    set_slot(0, 1'b1, 1'b1, 20, 0, 0);
    rename_fire = 1'b1;
    tick();
    clear_in();
    set_slot(0, 1'b1, 1'b1, 21, 5, 0);
    set_slot(1, 1'b1, 1'b1, 22, 0, 0);
    rename_fire = 1'b1;
    #2;
    chk("drain_count_1", int'(free_count), 1);
    chk("drain_stall", int'(stall), 1);
    tick();
    #2;
    chk("stall_no_change", int'(free_count), 1);
    chk("stall_held", int'(stall), 1);
    set_ret(0, 5, 4);
    tick();
    retire_valid = '0;
    #2;
    chk("stall_release", int'(stall), 0);
    chk("count_2", int'(free_count), 2);
    tick();
    clear_in();
    set_slot(0, 1'b1, 1'b1, 9, 5, 0);
    rename_fire = 1'b1;
    #2;
    chk("empty_count", int'(free_count), 0);
    chk("empty_stall", int'(stall), 1);
    chk("retired_src5", int'(psrc1[0].valid), 0);
    tick();

    // Flush, then sustained allocate/retire traffic that wraps the pointers.
    clear_in();
    flush = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      clear_in();
      set_slot(0, 1'b1, (i % 4) != 3, ((i * 7) % 31) + 1, i % 32, (i + 9) % 32);
      set_slot(1, (i % 5) != 4, (i % 3) != 0, (i * 5) % 32, (i + 3) % 32, (i * 11) % 32);
      rename_fire = (i % 7) != 6;
      nret = (inflight.size() >= 24) ? 2 : (i % 2);
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if ((j < nret) && (inflight.size() > 0)) begin
          p = inflight.pop_front();
          set_ret(j, p.dst, p.pdst);
        end
      end
      tick();
    end

    // Flush together with a rename and a retire.
    clear_in();
    set_slot(0, 1'b1, 1'b1, 3, 0, 0);
    set_slot(1, 1'b1, 1'b1, 4, 0, 0);
    rename_fire = 1'b1;
    if (inflight.size() > 0) begin
      p = inflight.pop_front();
      set_ret(0, p.dst, p.pdst);
    end
    flush = 1'b1;
    tick();
    clear_in();
    set_slot(0, 1'b1, 1'b1, 3, 0, 0);
    set_slot(1, 1'b1, 1'b1, 4, 12, 0);
    rename_fire = 1'b1;
    #2;
    chk("flush_count", int'(free_count), 64);
    chk("flush_pdst0", int'(pdst[0]), 64 + 0);
    chk("flush_pdst1", int'(pdst[1]), 64 + 1);
    chk("flush_rat", int'(psrc1[1].valid), 0);
    tick();
    clear_in();
    set_slot(0, 1'b0, 1'b0, 0, 3, 4);
    #2;
    chk("post_flush_map3", int'(psrc1[0]), 64 + 0);
    chk("post_flush_map4", int'(psrc2[0]), 64 + 1);
    chk("post_flush_count", int'(free_count), 62);

    // Asynchronous reset between clock edges.
    reset = 1'b1;
    #1;
    chk("async_rst_count", int'(free_count), 64);
    chk("async_rst_rat", int'(psrc1[0].valid), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #2;
    chk("rst_release_count", int'(free_count), 64);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
